// File: rtl/fdiv_if.sv
// fixedp: shared fixed-point format and clock/reset bundle
// for the matrix datapath element operators.
interface fixedp #(
    parameter int WIDTH = 16,
    parameter int SCALE = 8
);
    logic clk;
    logic reset;

    modport sink (input clk, input reset);
endinterface

// File: rtl/fdiv.sv
// fdiv: sequential signed fixed-point divider, f = a / b.
// Restoring shift/subtract, one quotient bit per clock.
module fdiv #(
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    fixedp.sink                g,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   f,
    output logic               dz,
    output logic               ovf
);
    localparam int N  = WIDTH + SCALE;
    localparam int CW = $clog2(N + 1);

    localparam logic [N-1:0] QPOS = N'((64'd1 << (WIDTH - 1)) - 64'd1);
    localparam logic [N-1:0] QNEG = N'(64'd1 << (WIDTH - 1));

    localparam logic [WIDTH-1:0] FMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             aneg_q, aneg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] amag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;

    // Next-state, iteration step and result fix-up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        aneg_d  = aneg_q;
        bzero_d = bzero_q;
        bmag_d  = bmag_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        f_d     = f_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        amag    = a[WIDTH-1] ? -a : a;
        rem_sh  = {rem_q[WIDTH-1:0], dvd_q[N-1]};
        rem_sub = rem_sh - {1'b0, bmag_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DIV;
                    cnt_d   = '0;
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    aneg_d  = a[WIDTH-1];
                    bzero_d = (b == '0);
                    bmag_d  = b[WIDTH-1] ? -b : b;
                    dvd_d   = {amag, {SCALE{1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                end
            end
            DIV: begin
                dvd_d = {dvd_q[N-2:0], 1'b0};
                if (rem_sh >= {1'b0, bmag_q}) begin
                    rem_d = rem_sub;
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = 1'b0;
                ovf_d   = 1'b0;
                if (bzero_q) begin
                    f_d  = aneg_q ? FMIN : FMAX;
                    dz_d = 1'b1;
                end else if (!sign_q && quo_q > QPOS) begin
                    f_d   = FMAX;
                    ovf_d = 1'b1;
                end else if (sign_q && quo_q > QNEG) begin
                    f_d   = FMIN;
                    ovf_d = 1'b1;
                end else if (sign_q) begin
                    f_d = -quo_q[WIDTH-1:0];
                end else begin
                    f_d = quo_q[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge g.clk or posedge g.reset) begin
        if (g.reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            aneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            bmag_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            f_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            aneg_q  <= aneg_d;
            bzero_q <= bzero_d;
            bmag_q  <= bmag_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            f_q     <= f_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign f    = f_q;
    assign dz   = dz_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: scoreboard bench for fdiv with a
// plain-arithmetic reference divider.
module tb_fdiv;
    localparam int W = 16;
    localparam int S = 8;
    localparam int N = W + S;

    fixedp #(.WIDTH(W), .SCALE(S)) g();

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic         dz;
    logic         ovf;

    fdiv #(.WIDTH(W), .SCALE(S)) dut (
        .g(g),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .f(f),
        .dz(dz),
        .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] f;
        logic         dz;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t sbq[$];

    int n_chk   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int free_at = 0;
    int last_t  = -1000;

    logic [W-1:0] cur_f   = '0;
    logic         cur_dz  = 1'b0;
    logic         cur_ovf = 1'b0;

    initial g.clk = 1'b0;
    always #5 g.clk = ~g.clk;

    always @(posedge g.clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Reference: quotient = (|a| * 2^S) / |b| with saturation.
    function automatic void ref_div(input logic [W-1:0] ia,
                                    input logic [W-1:0] ib,
                                    output logic [W-1:0] rf,
                                    output logic rdz,
                                    output logic rovf);
        longint sa;
        longint sb;
        longint q;
        bit     neg;
        sa   = longint'($signed(ia));
        sb   = longint'($signed(ib));
        rdz  = 1'b0;
        rovf = 1'b0;
        if (sb == 0) begin
            rdz = 1'b1;
            rf  = (sa >= 0) ? 16'h7FFF : 16'h8000;
            return;
        end
        neg = (sa < 0) != (sb < 0);
        q   = ((sa < 0 ? -sa : sa) * 256) / (sb < 0 ? -sb : sb);
        if (!neg && q > 32767) begin
            rovf = 1'b1;
            rf   = 16'h7FFF;
        end else if (neg && q > 32768) begin
            rovf = 1'b1;
            rf   = 16'h8000;
        end else begin
            rf = 16'(neg ? -q : q);
        end
    endfunction

    // Monitor: done timing, busy window, result and hold checks.
    always @(negedge g.clk) begin
        exp_t e;
        logic ed;
        if (!g.reset) begin
            ed = (sbq.size() > 0) && (sbq[0].due == cyc);
            check("done", done, ed);
            check("busy", busy, (cyc >= last_t) && (cyc <= last_t + N));
            if (ed) begin
                e = sbq.pop_front();
                if (done) begin
                    check("f", f, e.f);
                    check("dz", dz, e.dz);
                    check("ovf", ovf, e.ovf);
                end
                cur_f   = e.f;
                cur_dz  = e.dz;
                cur_ovf = e.ovf;
            end else begin
                check("f_hold", f, cur_f);
                check("flag_hold", {dz, ovf}, {cur_dz, cur_ovf});
            end
        end
    end

    // Drive one start pulse from a negedge; the model decides acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ef, input logic edz,
                         input logic eovf);
        int te;
        start = 1'b1;
        a     = ia;
        b     = ib;
        te    = cyc + 1;
        if (te >= free_at) begin
            sbq.push_back('{f: ef, dz: edz, ovf: eovf, due: te + N + 1});
            free_at = te + N + 2;
            last_t  = te;
        end
        @(negedge g.clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic issue_ref(input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [W-1:0] rf;
        logic         rdz;
        logic         rovf;
        ref_div(ia, ib, rf, rdz, rovf);
        issue(ia, ib, rf, rdz, rovf);
    endtask

    task automatic wait_free();
        while (cyc + 1 < free_at) @(negedge g.clk);
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 16'h0000;
            1:       v = 16'h8000;
            2:       v = 16'h7FFF;
            3:       v = W'($urandom_range(0, 255));
            4:       v = -W'($urandom_range(1, 255));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int t0;
        int guard;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        g.reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_f", f, 0);
        check("rst_flags", {dz, ovf}, 0);
        repeat (3) @(negedge g.clk);
        g.reset = 1'b0;
        @(negedge g.clk);

        issue(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);
        wait_free();
        issue(16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b0);
        wait_free();
        issue(16'hFD00, 16'hFE00, 16'h0180, 1'b0, 1'b0);
        wait_free();
        issue(16'h0100, 16'hFD00, 16'hFFAB, 1'b0, 1'b0);
        wait_free();
        issue(16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
        wait_free();
        issue(16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b0);
        wait_free();
        issue(16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
        wait_free();
        issue(16'h7F00, 16'h0040, 16'h7FFF, 1'b0, 1'b1);
        wait_free();
        issue(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0);
        wait_free();
        issue(16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1);
        wait_free();
        issue(16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0);

        wait_free();
        t0 = cyc + 1;
        issue(16'h0500, 16'h0200, 16'h0280, 1'b0, 1'b0);
        while (cyc + 1 < t0 + 5) @(negedge g.clk);
        issue(16'h1234, 16'h0001, 16'h0000, 1'b0, 1'b0);
        while (cyc + 1 < t0 + 10) @(negedge g.clk);
        issue(16'h4321, 16'h0002, 16'h0000, 1'b0, 1'b0);
        wait_free();
        issue(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);

        wait_free();
        t0 = cyc + 1;
        issue(16'h0700, 16'h0100, 16'h0700, 1'b0, 1'b0);
        while (cyc < t0 + 12) begin
            @(posedge g.clk);
            #1;
        end
        #1;
        g.reset = 1'b1;
        sbq.delete();
        free_at = 0;
        last_t  = -1000;
        cur_f   = '0;
        cur_dz  = 1'b0;
        cur_ovf = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_f", f, 0);
        check("mid_rst_flags", {dz, ovf}, 0);
        repeat (2) @(negedge g.clk);
        g.reset = 1'b0;
        @(negedge g.clk);
        issue(16'hFA00, 16'h0300, 16'hFE00, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            wait_free();
            repeat ($urandom_range(0, 2)) @(negedge g.clk);
            issue_ref(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge g.clk);
                issue_ref(rand_op(), rand_op());
            end
        end

        guard = 0;
        while (sbq.size() > 0 && guard < 200) begin
            @(negedge g.clk);
            guard++;
        end
        check("drain", sbq.size(), 0);
        repeat (3) @(negedge g.clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
